// File: rtl/fpu_pkg.sv
// fpu_pkg: shared class/state enums, operand field widths and exponent constant helpers
package fpu_pkg;
  localparam int MANT_W = 23;
  localparam int EXP_W = 8;
  localparam int OP_W = 1 + EXP_W + MANT_W;
  typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic int min_exp_of(input int ew);
    return 1 - bias_of(ew);
  endfunction
endpackage

// File: rtl/prenorm_unpack.sv
// prenorm_unpack: splits a packed operand, classifies it and forms the initial unbiased exponent.
// PRENORM_FTZ_EN flushes subnormals to signed zero.
module prenorm_unpack
  import fpu_pkg::*;
#(
  parameter int mant_width = MANT_W,
  parameter int exp_width = EXP_W
) (
  input  logic [exp_width+mant_width:0]  op,
  output logic                           sign,
  output logic [mant_width:0]            mant,
  output logic signed [exp_width+1:0]    exp,
  output cls_t                           cls
);
`ifdef PRENORM_FTZ_EN
  localparam bit ftz = 1'b1;
`else
  localparam bit ftz = 1'b0;
`endif
  localparam logic signed [exp_width+1:0] bias_v = (exp_width+2)'(bias_of(exp_width));
  localparam logic signed [exp_width+1:0] min_exp_v = (exp_width+2)'(min_exp_of(exp_width));
  logic [exp_width-1:0] fld;
  logic [mant_width-1:0] frac;
  logic e_max, e_zero, f_zero, is_zero;
  always_comb begin
    fld = op[exp_width+mant_width-1:mant_width];
    frac = op[mant_width-1:0];
    sign = op[exp_width+mant_width];
    e_max = &fld;
    e_zero = ~|fld;
    f_zero = ~|frac;
    is_zero = e_zero && (f_zero || ftz);
    cls = e_max ? (f_zero ? CLS_INF : CLS_NAN) : is_zero ? CLS_ZERO : CLS_NORMAL;
    mant = is_zero ? '0 : {~e_zero, frac};
    exp = (e_max || is_zero) ? '0 : e_zero ? min_exp_v : $signed({2'b00, fld}) - bias_v;
  end
endmodule

// File: rtl/prenormaliser_muldiv.sv
// prenormaliser_muldiv: operand front end for mul/div; unpacks both operands and iteratively
// left-normalises subnormal mantissas. PRENORM_FTZ_EN (in prenorm_unpack) flushes subnormals.
module prenormaliser_muldiv
  import fpu_pkg::*;
#(
  parameter int mant_width = MANT_W,
  parameter int exp_width = EXP_W,
  parameter int shift_per_cycle = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [exp_width+mant_width:0] op_a,
  input  logic [exp_width+mant_width:0] op_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sign_a,
  output logic                          sign_b,
  output logic [mant_width:0]           mant_a,
  output logic [mant_width:0]           mant_b,
  output logic signed [exp_width+1:0]   exp_a,
  output logic signed [exp_width+1:0]   exp_b,
  output logic [1:0]                    cls_a,
  output logic [1:0]                    cls_b
);
  localparam int SW = $clog2(mant_width + 2);
  localparam logic [SW-1:0] spc_v = SW'(shift_per_cycle);
  state_t state, state_nx;
  logic u_sign_a, u_sign_b, pend_a, pend_b;
  logic [mant_width:0] u_mant_a, u_mant_b;
  logic signed [exp_width+1:0] u_exp_a, u_exp_b;
  cls_t u_cls_a, u_cls_b;
  logic [SW-1:0] s_a, s_b;
  prenorm_unpack #(.mant_width(mant_width), .exp_width(exp_width)) u_unpack_a (
    .op(op_a), .sign(u_sign_a), .mant(u_mant_a), .exp(u_exp_a), .cls(u_cls_a)
  );
  prenorm_unpack #(.mant_width(mant_width), .exp_width(exp_width)) u_unpack_b (
    .op(op_b), .sign(u_sign_b), .mant(u_mant_b), .exp(u_exp_b), .cls(u_cls_b)
  );
  // leading-zero count clamped to the per-cycle shift limit
  function automatic logic [SW-1:0] shamt(input logic [mant_width:0] m);
    logic [SW-1:0] lz;
    logic hit;
    lz = '0;
    hit = 1'b0;
    for (int i = mant_width; i >= 0; i--) begin
      hit = hit | m[i];
      lz = hit ? lz : lz + 1'b1;
    end
    return (lz > spc_v) ? spc_v : lz;
  endfunction
  always_comb begin
    pend_a = (cls_a == 2'(CLS_NORMAL)) && !mant_a[mant_width];
    pend_b = (cls_b == 2'(CLS_NORMAL)) && !mant_b[mant_width];
    s_a = shamt(mant_a);
    s_b = shamt(mant_b);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? NORM : IDLE;
      NORM: state_nx = (pend_a || pend_b) ? NORM : DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sign_a, sign_b, mant_a, mant_b, exp_a, exp_b, cls_a, cls_b} <= '0;
    end else if (state == IDLE && in_valid) begin
      sign_a <= u_sign_a;
      sign_b <= u_sign_b;
      mant_a <= u_mant_a;
      mant_b <= u_mant_b;
      exp_a <= u_exp_a;
      exp_b <= u_exp_b;
      cls_a <= u_cls_a;
      cls_b <= u_cls_b;
    end else if (state == NORM) begin
      if (pend_a) begin
        mant_a <= mant_a << s_a;
        exp_a <= exp_a - (exp_width+2)'(s_a);
      end
      if (pend_b) begin
        mant_b <= mant_b << s_b;
        exp_b <= exp_b - (exp_width+2)'(s_b);
      end
    end
  end
endmodule
